data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//   Memory-side responder for the core's load/store port. It accepts one request at a
//   time over a valid/ready handshake and inserts a configurable number of wait states.
//   It then performs a byte, half or word access on an internal word array and returns
//   one response pulse. It is the slave end of the interface that drives ALUResult,
//   WriteData and ReadData, and models a slow data memory mapped at BASE_ADDR.
// PARAMETERS
//   BASE_ADDR    32'h0000_2000  byte address of word 0
//   DEPTH_WORDS  1024           number of 32-bit words (power of two)
//   WAIT_CYCLES  2              wait states between accept and access (0..15)
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous, active-low reset
//   req_valid     in   1   request present
//   req_ready     out  1   responder can accept (IDLE only)
//   req_we        in   1   1 = store, 0 = load
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//   req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//   resp_valid    out  1   one-cycle response pulse
//   resp_rdata    out  32  load result, extended; 0 for stores
//   resp_err      out  1   access faulted (qualified by resp_valid)
// BEHAVIOUR
//   Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
//   Memory contents are not reset.
//   FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready=1. On an edge where req_valid=1, the request fields are latched,
//     cnt<=WAIT_CYCLES and the FSM moves to WAIT. Inputs are ignored after this latch.
//   - WAIT: req_ready=0. If cnt!=0, cnt decrements. If cnt==0, the access is performed
//     on this edge, resp_* are registered and the FSM moves to RESP.
//   - RESP: resp_valid=1 for exactly one cycle, req_ready=0. The next edge returns to
//     IDLE.
//   Latency: accept on edge E0 -> access and resp_valid rise on edge E0+WAIT_CYCLES+1.
//   Maximum throughput is one request per WAIT_CYCLES+3 cycles.
//   resp_rdata/resp_err hold their last value outside RESP.
//   Word index = (addr-BASE_ADDR)>>2; lane = addr[1:0].
//   Store byte lanes: byte writes lane only; half writes lanes {addr[1],0}..+1; word
//   writes all four lanes.
//   Load: the selected lane(s) are right-aligned, then sign- or zero-extended per
//   req_unsigned. Word loads ignore req_unsigned.
//   A store to a location followed by a load of it returns the new data (no bypass is
//   needed, because the accesses are serialised).
//   Reset mid-operation: an asynchronous return to IDLE discards the pending request. A
//   store still in WAIT is never committed and no response is issued.
//   rst deasserted with req_valid=1: the request is accepted on the first rising edge
//   after release.
// CONFIGURATION
//   MEM_ERR_EN defined:
//     - A fault is any of: misaligned access (half with addr[0]=1, or word with
//       addr[1:0]!=0), size 11, or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
//     - On a fault: no memory write, resp_rdata=0, resp_err=1. Latency is unchanged.
//   MEM_ERR_EN undefined:
//     - resp_err is constant 0.
//     - Size 11 is treated as a word access.
//     - Misaligned accesses ignore the low address bits (half uses addr[1], word uses
//       lane 0).
//     - The word index wraps modulo DEPTH_WORDS.
// TESTING (WAIT_CYCLES=2 unless noted)
//   1. sw 0xDEADBEEF @0x2000, then lw @0x2000 -> resp_valid rises 3 edges after each
//      accept, rdata=0xDEADBEEF, err=0.
//   2. sw 0 @0x2004; sb 0x80 @0x2005; lb @0x2005 -> 0xFFFFFF80; lbu -> 0x00000080;
//      lw @0x2004 -> 0x00008000.
//   3. sh 0x8001 @0x2002 over 0xDEADBEEF at 0x2000; lh @0x2002 -> 0xFFFF8001;
//      lw @0x2000 -> 0x8001BEEF.
//   4. MEM_ERR_EN defined: lw @0x2002 -> err=1, rdata=0; sw @0x1FFC -> err=1 and
//      mem unchanged. MEM_ERR_EN undefined: lw @0x2002 -> word at 0x2000, err=0.
//   5. sw 0x11111111 @0x2008, then pull rst low during WAIT -> no resp_valid,
//      req_ready=1 after release, lw @0x2008 returns the old value.
//   6. req_valid held high for 20 cycles with WAIT_CYCLES=0, then 3 -> accepts every
//      3, then every 6 cycles; req_ready=0 throughout WAIT and RESP.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: slow data-memory slave for the core's load/store port.
// It takes one request at a time over valid/ready, waits WAIT_CYCLES, then
// performs a byte/half/word access on an internal word array and pulses
// resp_valid for one cycle.
// Optional feature macro: MEM_ERR_EN (fault detection for misaligned, reserved
// size and out-of-range accesses). Without it, accesses are forced aligned and
// the word index wraps.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [1:0]       lat_size;
  logic             lat_unsigned;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      cur_word;
  logic [31:0]      load_data;
  logic [31:0]      store_word;
  logic             fault;
  logic             do_access;
  logic             unused_bits;

  assign offset    = lat_addr - BASE_ADDR;
  assign idx       = offset[IDX_W+1:2];
  assign lane      = lat_addr[1:0];
  assign cur_word  = mem[idx];
  assign do_access = (state == S_WAIT) && (cnt == 4'd0);
  assign req_ready = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

`ifdef MEM_ERR_EN
  // Misaligned, reserved-size and out-of-window accesses fault; an address
  // below BASE_ADDR wraps to a huge offset and is caught by the range test.
  assign fault = ((lat_size == 2'b01) && lat_addr[0]) ||
                 ((lat_size == 2'b10) && (lat_addr[1:0] != 2'b00)) ||
                 (lat_size == 2'b11) ||
                 (offset[31:IDX_W+2] != '0);
  assign unused_bits = ^offset[1:0];
`else
  assign fault = 1'b0;
  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

  // Lane selection and extension for loads, lane merge for stores.
  always_comb begin
    load_data  = cur_word;
    store_word = lat_wdata;
    case (lat_size)
      2'b00: begin
        logic [7:0] b;
        case (lane)
          2'd0:    b = cur_word[7:0];
          2'd1:    b = cur_word[15:8];
          2'd2:    b = cur_word[23:16];
          default: b = cur_word[31:24];
        endcase
        load_data = lat_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
        store_word = cur_word;
        case (lane)
          2'd0:    store_word[7:0]   = lat_wdata[7:0];
          2'd1:    store_word[15:8]  = lat_wdata[7:0];
          2'd2:    store_word[23:16] = lat_wdata[7:0];
          default: store_word[31:24] = lat_wdata[7:0];
        endcase
      end
      2'b01: begin
        logic [15:0] h;
        h = lane[1] ? cur_word[31:16] : cur_word[15:0];
        load_data = lat_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
        store_word = cur_word;
        if (lane[1]) store_word[31:16] = lat_wdata[15:0];
        else         store_word[15:0]  = lat_wdata[15:0];
      end
      default: begin
        load_data  = cur_word;
        store_word = lat_wdata;
      end
    endcase
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && lat_we && !fault) mem[idx] <= store_word;
  end

  // Request FSM: latch in IDLE, count wait states, register the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            cnt          <= 4'(WAIT_CYCLES);
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_rdata <= (fault || lat_we) ? 32'd0 : load_data;
            resp_err   <= fault;
            state      <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
